// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction fetch path.
package riscv_pkg;

  // Fetch handshake progress: issue request, await data, present to core.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

  // addi x0, x0, 0 -- what the instr register holds before the first fetch.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Base opcodes the downstream decoder switches on.
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;

endpackage

// File: rtl/fetch_pc_gen.sv
// Next-PC selection: flush beats a taken branch/jump, which beats PC+4.
// The chosen address is word-aligned, and misaligned reports that a redirect
// target had non-zero low bits.
module fetch_pc_gen #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_pc,
  input  logic            advance,
  input  logic            pc_src,
  input  logic [XLEN-1:0] pc_target,
  output logic            pc_load,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  logic [XLEN-1:0] raw_pc;

  // Priority select of the next fetch address and its alignment flag.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    raw_pc     = pc + XLEN'(4);
    pc_load    = 1'b0;
    misaligned = 1'b0;
    if (flush) begin
      raw_pc     = flush_pc;
      pc_load    = 1'b1;
      misaligned = |flush_pc[1:0];
    end else if (advance) begin
      pc_load = 1'b1;
      if (pc_src) begin
        raw_pc     = pc_target;
        misaligned = |pc_target[1:0];
      end
    end
  end

  // PC+4 wraps naturally in XLEN bits; low two bits are always cleared.
  assign next_pc = raw_pc & ~XLEN'(3);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one word per instruction over
// a req/gnt + rvalid handshake, presents the word and its decode fields to
// the core, and steps or redirects the PC when the core accepts it.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [6:0]      op,
  output logic [2:0]      funct3,
  output logic            funct7b5,
  output logic [XLEN-1:0] pc,
  input  logic            pc_src,
  input  logic [XLEN-1:0] pc_target,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_pc,
  output logic            misaligned
);

  fetch_state_t    state, state_nxt;
  logic [31:0]     instr_nxt;
  logic            valid_nxt;
  logic            kill, kill_nxt;
  logic            advance;
  logic            pc_load;
  logic [XLEN-1:0] next_pc;
  logic            misaligned_nxt;

  // The core takes the presented instruction only while it is being held.
  assign advance = (state == S_HOLD) && instr_ready;

  fetch_pc_gen #(.XLEN(XLEN)) u_pc_gen (
    .pc         (pc),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .advance    (advance),
    .pc_src     (pc_src),
    .pc_target  (pc_target),
    .pc_load    (pc_load),
    .next_pc    (next_pc),
    .misaligned (misaligned_nxt)
  );

  // Next-state logic for the fetch handshake; flush overrides everything.
  always_comb begin
    state_nxt = state;
    instr_nxt = instr;
    valid_nxt = instr_valid;
    kill_nxt  = kill;

    unique case (state)
      S_REQ: begin
        if (imem_gnt) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (kill) begin
            // Response belongs to a fetch that a flush has abandoned.
            kill_nxt  = 1'b0;
            state_nxt = S_REQ;
          end else begin
            instr_nxt = imem_rdata;
            valid_nxt = 1'b1;
            state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (instr_ready) begin
          valid_nxt = 1'b0;
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_REQ;
    endcase

    if (flush) begin
      valid_nxt = 1'b0;
      case (state)
        S_REQ: begin
          // A grant in the flush cycle still owes us one response to discard.
          if (imem_gnt) begin
            state_nxt = S_WAIT;
            kill_nxt  = 1'b1;
          end else begin
            state_nxt = S_REQ;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            // The outstanding response arrives now: drop it and refetch.
            instr_nxt = instr;
            kill_nxt  = 1'b0;
            state_nxt = S_REQ;
          end else begin
            kill_nxt  = 1'b1;
            state_nxt = S_WAIT;
          end
        end
        default: state_nxt = S_REQ;
      endcase
    end
  end

  // State, PC, instruction and flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
      kill        <= 1'b0;
      misaligned  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values regardless of statement order.
      state       <= state_nxt;
      instr       <= instr_nxt;
      instr_valid <= valid_nxt;
      kill        <= kill_nxt;
      misaligned  <= misaligned_nxt;
      if (pc_load) pc <= next_pc;
    end
  end

  // Request side depends only on registered state, never on same-cycle inputs.
  assign imem_req  = (state == S_REQ);
  assign imem_addr = {pc[XLEN-1:2], 2'b00};

  // Decode fields are plain slices of the held instruction word.
  assign op       = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7b5 = instr[30];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: the stimulus thread queues expected
// fetch addresses and presented instructions; a monitor pops and compares
// them whenever the DUT issues a granted request or raises instr_valid.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7b5;
  } exp_instr_t;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [31:0] pc;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        flush;
  logic [31:0] flush_pc;
  logic        misaligned;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_addr_q[$];
  exp_instr_t  exp_instr_q[$];
  logic [31:0] mem[logic [31:0]];
  int          rdelay = 0;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .op          (op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .pc          (pc),
    .pc_src      (pc_src),
    .pc_target   (pc_target),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .misaligned  (misaligned)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : NOP;
  endfunction

  // Instruction memory: grants any request outside reset when idle, answers
  // rdelay cycles after the cycle following the grant. Pending responses
  // survive a DUT reset, as a real memory's would.
  initial begin
    logic        pending = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = '0;
    logic        gnt_d = 1'b0;
    logic [31:0] gaddr = '0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (gnt_d && !reset) begin
        pending = 1'b1;
        cnt     = rdelay;
        paddr   = gaddr;
      end
      imem_rvalid = 1'b0;
      if (pending) begin
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(paddr);
          pending     = 1'b0;
        end else begin
          cnt--;
        end
      end
      imem_gnt = imem_req && !reset && !pending;
      gnt_d    = imem_gnt;
      gaddr    = imem_addr;
    end
  end

  // Monitor: compares granted addresses and each new instruction presentation.
  initial begin
    int         cyc = 0;
    int         grant_cyc = 0;
    int         grant_rd = 0;
    logic       valid_prev = 1'b0;
    exp_instr_t e;
    logic [31:0] ea;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (!reset && imem_req && imem_gnt) begin
        if (exp_addr_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL fetch_addr: unexpected request to 0x%08h, expected none", imem_addr);
        end else begin
          ea = exp_addr_q.pop_front();
          check("fetch_addr", imem_addr, ea);
        end
        grant_cyc = cyc;
        grant_rd  = rdelay;
      end
      if (!reset && instr_valid && !valid_prev) begin
        if (exp_instr_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL instr_present: unexpected instr 0x%08h at pc 0x%08h, expected none", instr, pc);
        end else begin
          e = exp_instr_q.pop_front();
          check("instr", instr, e.instr);
          check("pc", pc, e.pc);
          check("op", 32'(op), 32'(e.op));
          check("funct3", 32'(funct3), 32'(e.f3));
          check("funct7b5", 32'(funct7b5), 32'(e.f7b5));
          check("latency", 32'(cyc - grant_cyc), 32'(2 + grant_rd));
        end
      end
      valid_prev = instr_valid;
    end
  end

  task automatic expect_fetch(input logic [31:0] addr, input bit with_data,
                              input logic [31:0] word, input logic [6:0] e_op,
                              input logic [2:0] e_f3, input logic e_f7);
    exp_instr_t e;
    exp_addr_q.push_back(addr);
    if (with_data) begin
      e.instr = word;
      e.pc    = addr;
      e.op    = e_op;
      e.f3    = e_f3;
      e.f7b5  = e_f7;
      exp_instr_q.push_back(e);
    end
  endtask

  task automatic expect_nop(input logic [31:0] addr);
    expect_fetch(addr, 1'b1, NOP, 7'h13, 3'd0, 1'b0);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      #4;
      n++;
    end while (!instr_valid && n < 40);
    check({name, "_timeout"}, 32'(instr_valid), 32'd1);
  endtask

  task automatic wait_grant(input string name);
    int n = 0;
    while (!(imem_req && imem_gnt) && n < 40) begin
      @(negedge clk);
      #2;
      n++;
    end
    check({name, "_timeout"}, 32'(imem_req && imem_gnt), 32'd1);
  endtask

  task automatic accept(input logic src, input logic [31:0] tgt);
    instr_ready = 1'b1;
    pc_src      = src;
    pc_target   = tgt;
    @(negedge clk);
    #3;
    instr_ready = 1'b0;
    pc_src      = 1'b0;
  endtask

  initial begin
    mem[32'h0000_000C] = 32'h4000_0033;
    mem[32'h0000_0304] = 32'h0040_0093;
    reset       = 1'b1;
    instr_ready = 1'b0;
    pc_src      = 1'b0;
    pc_target   = '0;
    flush       = 1'b0;
    flush_pc    = '0;

    // Reset values
    repeat (2) @(negedge clk);
    #3;
    check("rst_pc", pc, 32'h0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, NOP);
    check("rst_misaligned", 32'(misaligned), 32'd0);

    // Sequential fetches from reset with a zero-wait memory
    expect_nop(32'h0);
    reset = 1'b0;
    wait_valid("f0");
    expect_nop(32'h4);
    accept(1'b0, '0);
    wait_valid("f4");
    expect_nop(32'h8);
    accept(1'b0, '0);
    wait_valid("f8");
    expect_fetch(32'hC, 1'b1, 32'h4000_0033, 7'h33, 3'd0, 1'b1);
    accept(1'b0, '0);
    wait_valid("fC");

    // pc_src without ready must not move anything
    pc_src    = 1'b1;
    pc_target = 32'h300;
    repeat (3) begin
      @(negedge clk);
      #4;
    end
    check("hold_pc", pc, 32'hC);
    check("hold_valid", 32'(instr_valid), 32'd1);
    check("hold_no_req", 32'(imem_req), 32'd0);

    // Taken branch to an aligned target
    expect_nop(32'h100);
    accept(1'b1, 32'h100);
    check("aligned_no_flag", 32'(misaligned), 32'd0);
    wait_valid("f100");

    // Flush while waiting on a slow response: that data must be dropped
    rdelay = 2;
    expect_fetch(32'h104, 1'b0, '0, '0, '0, 1'b0);
    accept(1'b0, '0);
    wait_grant("g104");
    @(negedge clk);
    #3;
    flush    = 1'b1;
    flush_pc = 32'h200;
    expect_nop(32'h200);
    @(negedge clk);
    #3;
    flush  = 1'b0;
    rdelay = 0;
    wait_valid("f200");

    // Misaligned branch target is aligned and flagged for exactly one cycle
    expect_nop(32'h100);
    accept(1'b1, 32'h102);
    check("misaligned_pulse", 32'(misaligned), 32'd1);
    check("misaligned_pc", pc, 32'h100);
    @(negedge clk);
    #3;
    check("misaligned_clear", 32'(misaligned), 32'd0);
    wait_valid("f100b");

    // PC+4 wraps from the top of the address space
    expect_nop(32'hFFFF_FFFC);
    accept(1'b1, 32'hFFFF_FFFC);
    wait_valid("ftop");
    expect_nop(32'h0);
    accept(1'b0, '0);
    wait_valid("fwrap");

    // Flush in the hold state beats a same-cycle taken branch
    expect_nop(32'h300);
    flush       = 1'b1;
    flush_pc    = 32'h301;
    instr_ready = 1'b1;
    pc_src      = 1'b1;
    pc_target   = 32'h500;
    @(negedge clk);
    #3;
    flush       = 1'b0;
    instr_ready = 1'b0;
    pc_src      = 1'b0;
    check("flush_misaligned", 32'(misaligned), 32'd1);
    check("flush_pc", pc, 32'h300);
    check("flush_valid", 32'(instr_valid), 32'd0);
    wait_valid("f300");

    // Reset mid-transaction; the stale response returns after release
    rdelay = 3;
    expect_fetch(32'h304, 1'b0, '0, '0, '0, 1'b0);
    accept(1'b0, '0);
    wait_grant("g304");
    @(negedge clk);
    #3;
    reset  = 1'b1;
    rdelay = 0;
    #1;
    check("midrst_pc", pc, 32'h0);
    check("midrst_valid", 32'(instr_valid), 32'd0);
    expect_nop(32'h0);
    repeat (2) @(negedge clk);
    #3;
    reset = 1'b0;
    wait_valid("frst");

    repeat (3) @(negedge clk);
    check("addr_q_drained", 32'(exp_addr_q.size()), 32'd0);
    check("instr_q_drained", 32'(exp_instr_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
